// File: rtl/mips_pkg.sv
// Shared definitions for the ALU arbiter slice.
// Contents: datapath width, ALU op-code constants and a zero-detect helper.
package mips_pkg;

    localparam int DATA_W = 32;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 3'b000;
    localparam alu_op_t ALU_SUB = 3'b001;
    localparam alu_op_t ALU_AND = 3'b010;
    localparam alu_op_t ALU_OR  = 3'b011;
    localparam alu_op_t ALU_SLT = 3'b100;

    // True when every bit of the value is clear.
    function automatic logic is_zero(input logic [DATA_W-1:0] value);
        return (value == {DATA_W{1'b0}});
    endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational 32-bit ALU.
// Ports:
//   a, b    in  DATA_W  operands
//   op      in  3       op code (unused codes execute as add)
//   result  out DATA_W  result, add/sub wrap modulo 2^DATA_W
//   zero    out 1       result == 0
module mips_alu
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    // Operation select; set-less-than is an unsigned compare.
    always_comb begin
        result = {DATA_W{1'b0}};
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = (a < b) ? {{(DATA_W-1){1'b0}}, 1'b1} : {DATA_W{1'b0}};
            default: result = a + b;
        endcase
        zero = is_zero(result);
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way arbiter with eligibility inputs and a last-winner pointer.
// Ports:
//   clk      in  1  clock
//   reset_n  in  1  asynchronous active-low reset
//   elig     in  2  per-port eligibility
//   grant    out 2  one-hot or zero grant (combinational)
// FAIR=1 alternates on contention, FAIR=0 always favours port 0.
module rr_arb2 #(
    parameter bit FAIR = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] elig,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    // Grant selection; with both eligible the fair mode picks the port that did not win last.
    always_comb begin
        grant = 2'b00;
        case (elig)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                if (FAIR == 1'b0) begin
                    grant = 2'b01;
                end else if (last_q) begin
                    grant = 2'b01;
                end else begin
                    grant = 2'b10;
                end
            end
            default: grant = 2'b00;
        endcase
    end

    // Any grant is a completed handshake, since a port is only eligible while valid.
    always_comb begin
        last_d = last_q;
        if (grant[0]) begin
            last_d = 1'b0;
        end else if (grant[1]) begin
            last_d = 1'b1;
        end else begin
            last_d = last_q;
        end
    end

    // Last-winner pointer; resets to port 1 so port 0 wins the first contest.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with per-port response slots.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   req_valid / req_ready     per-port request handshake (ready is combinational)
//   req_a*, req_b*, req_op*   operands and op code, ports 0/1
//   rsp_valid / rsp_ready     per-port response handshake
//   rsp_result*, rsp_zero*    registered result and zero flag, ports 0/1
// Latency is two cycles from request handshake to rsp_valid.
module alu_arbiter
    import mips_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_b1,
    input  logic [2:0]        req_op0,
    input  logic [2:0]        req_op1,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_result0,
    output logic [DATA_W-1:0] rsp_result1,
    output logic              rsp_zero0,
    output logic              rsp_zero1
);

    logic              s1_valid_q, s1_valid_d;
    logic              s1_owner_q, s1_owner_d;
    logic [DATA_W-1:0] s1_a_q, s1_a_d;
    logic [DATA_W-1:0] s1_b_q, s1_b_d;
    logic [2:0]        s1_op_q, s1_op_d;

    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] result0_q, result0_d;
    logic [DATA_W-1:0] result1_q, result1_d;
    logic              zero0_q, zero0_d;
    logic              zero1_q, zero1_d;

    logic [1:0]        elig_s;
    logic [1:0]        grant_s;
    logic [DATA_W-1:0] alu_result_s;
    logic              alu_zero_s;

    // A port may have only one op in flight: blocked while it owns the issue slot or a full response slot.
    always_comb begin
        elig_s[0] = req_valid[0] & ~rsp_valid_q[0] & ~(s1_valid_q & (s1_owner_q == 1'b0));
        elig_s[1] = req_valid[1] & ~rsp_valid_q[1] & ~(s1_valid_q & (s1_owner_q == 1'b1));
    end

    rr_arb2 #(
        .FAIR (FAIR)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .elig    (elig_s),
        .grant   (grant_s)
    );

    assign req_ready = grant_s;

    mips_alu u_alu (
        .a      (s1_a_q),
        .b      (s1_b_q),
        .op     (s1_op_q),
        .result (alu_result_s),
        .zero   (alu_zero_s)
    );

    // Issue register next state: capture the granted port, otherwise the slot empties.
    always_comb begin
        s1_valid_d = 1'b0;
        s1_owner_d = s1_owner_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (grant_s[0]) begin
            s1_valid_d = 1'b1;
            s1_owner_d = 1'b0;
            s1_a_d     = req_a0;
            s1_b_d     = req_b0;
            s1_op_d    = req_op0;
        end else if (grant_s[1]) begin
            s1_valid_d = 1'b1;
            s1_owner_d = 1'b1;
            s1_a_d     = req_a1;
            s1_b_d     = req_b1;
            s1_op_d    = req_op1;
        end else begin
            s1_valid_d = 1'b0;
        end
    end

    // Response slot next state; a write and a consume of the same slot never coincide.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        result0_d   = result0_q;
        result1_d   = result1_q;
        zero0_d     = zero0_q;
        zero1_d     = zero1_q;
        if (s1_valid_q && (s1_owner_q == 1'b0)) begin
            rsp_valid_d[0] = 1'b1;
            result0_d      = alu_result_s;
            zero0_d        = alu_zero_s;
        end else if (rsp_valid_q[0] && rsp_ready[0]) begin
            rsp_valid_d[0] = 1'b0;
        end else begin
            rsp_valid_d[0] = rsp_valid_q[0];
        end
        if (s1_valid_q && (s1_owner_q == 1'b1)) begin
            rsp_valid_d[1] = 1'b1;
            result1_d      = alu_result_s;
            zero1_d        = alu_zero_s;
        end else if (rsp_valid_q[1] && rsp_ready[1]) begin
            rsp_valid_d[1] = 1'b0;
        end else begin
            rsp_valid_d[1] = rsp_valid_q[1];
        end
    end

    // Issue-stage registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_owner_q <= 1'b0;
            s1_a_q     <= {DATA_W{1'b0}};
            s1_b_q     <= {DATA_W{1'b0}};
            s1_op_q    <= 3'b000;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_owner_q <= s1_owner_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
        end
    end

    // Response-slot registers; reset discards any pending result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q <= 2'b00;
            result0_q   <= {DATA_W{1'b0}};
            result1_q   <= {DATA_W{1'b0}};
            zero0_q     <= 1'b0;
            zero1_q     <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            result0_q   <= result0_d;
            result1_q   <= result1_d;
            zero0_q     <= zero0_d;
            zero1_q     <= zero1_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_result0 = result0_q;
    assign rsp_result1 = result1_q;
    assign rsp_zero0   = zero0_q;
    assign rsp_zero1   = zero1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one fair and one fixed-priority instance share all inputs.
module tb_alu_arbiter;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [31:0] req_a0, req_a1, req_b0, req_b1;
    logic [2:0]  req_op0, req_op1;
    logic [1:0]  rsp_ready;

    logic [1:0]  f_req_ready, f_rsp_valid, p_req_ready, p_rsp_valid;
    logic [31:0] f_res0, f_res1, p_res0, p_res1;
    logic        f_z0, f_z1, p_z0, p_z1;

    int total = 0;
    int bad   = 0;

    logic [1:0] con_rdy [0:5] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
    logic [1:0] con_rsp [0:5] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
    logic [1:0] fair_f  [0:4] = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b01};
    logic [1:0] fair_p  [0:4] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10};

    alu_arbiter #(.FAIR(1'b1)) u_fair (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(f_req_ready),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .req_op0(req_op0), .req_op1(req_op1), .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result0(f_res0), .rsp_result1(f_res1), .rsp_zero0(f_z0), .rsp_zero1(f_z1)
    );

    alu_arbiter #(.FAIR(1'b0)) u_prio (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(p_req_ready),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .req_op0(req_op0), .req_op1(req_op1), .rsp_valid(p_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result0(p_res0), .rsp_result1(p_res1), .rsp_zero0(p_z0), .rsp_zero1(p_z1)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One port-0 op from idle, consumed the cycle it appears.
    task automatic run_op0(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic [31:0] er, input logic ez);
        @(negedge clk);
        req_valid = 2'b01; req_a0 = a; req_b0 = b; req_op0 = op;
        #1 chk({tag, "_rdy"}, 32'(f_req_ready), 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        #1 chk({tag, "_early"}, 32'(f_rsp_valid), 32'd0);
        @(negedge clk);
        #1 chk({tag, "_vld"}, 32'(f_rsp_valid), 32'd1);
        chk({tag, "_res"}, f_res0, er);
        chk({tag, "_zero"}, 32'(f_z0), 32'(ez));
        chk({tag, "_pres"}, p_res0, er);
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1 chk({tag, "_clr"}, 32'(f_rsp_valid), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
        req_a0 = 32'd0; req_a1 = 32'd0; req_b0 = 32'd0; req_b1 = 32'd0;
        req_op0 = 3'd0; req_op1 = 3'd0;

        // reset state
        repeat (2) @(negedge clk);
        #1 chk("rst_rv", 32'(f_rsp_valid), 32'd0);
        chk("rst_res0", f_res0, 32'd0);
        chk("rst_res1", f_res1, 32'd0);
        chk("rst_z", 32'({f_z1, f_z0}), 32'd0);
        chk("rst_prv", 32'(p_rsp_valid), 32'd0);
        @(negedge clk) reset_n = 1'b1;

        // single sub op, latency 2, held under backpressure
        @(negedge clk);
        req_valid = 2'b01; req_a0 = 32'd5; req_b0 = 32'd3; req_op0 = 3'b001;
        #1 chk("sub_rdy", 32'(f_req_ready), 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        #1 chk("sub_lat1", 32'(f_rsp_valid), 32'd0);
        @(negedge clk);
        #1 chk("sub_lat2", 32'(f_rsp_valid), 32'd1);
        chk("sub_res", f_res0, 32'd2);
        chk("sub_zero", 32'(f_z0), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 2'b01;
            #1 chk("hold_vld", 32'(f_rsp_valid), 32'd1);
            chk("hold_res", f_res0, 32'd2);
            chk("hold_rdy", 32'(f_req_ready), 32'd0);
        end
        @(negedge clk);
        req_valid = 2'b00; rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1 chk("sub_clr", 32'(f_rsp_valid), 32'd0);

        // unsigned slt, default op, and-to-zero
        run_op0("slt_u", 32'h8000_0000, 32'd1, 3'b100, 32'd0, 1'b1);
        run_op0("op111", 32'd2, 32'd3, 3'b111, 32'd5, 1'b0);
        run_op0("and_z", 32'h0000_00F0, 32'h0000_000F, 3'b010, 32'd0, 1'b1);

        // backpressure on port 1
        @(negedge clk);
        rsp_ready = 2'b01; req_valid = 2'b10;
        req_a1 = 32'd7; req_b1 = 32'd7; req_op1 = 3'b001;
        #1 chk("bp_rdy0", 32'(f_req_ready), 32'd2);
        @(negedge clk);
        req_valid = 2'b00;
        #1 chk("bp_rdy1", 32'(f_req_ready), 32'd0);
        @(negedge clk);
        #1 chk("bp_rv2", 32'(f_rsp_valid), 32'd2);
        chk("bp_res1", f_res1, 32'd0);
        chk("bp_z1", 32'(f_z1), 32'd1);
        req_valid = 2'b11; req_a0 = 32'd10; req_b0 = 32'd20; req_op0 = 3'b011;
        #1 chk("bp_rdy2", 32'(f_req_ready), 32'd1);
        @(negedge clk);
        #1 chk("bp_rdy3", 32'(f_req_ready), 32'd0);
        @(negedge clk);
        #1 chk("bp_rdy4", 32'(f_req_ready), 32'd0);
        chk("bp_rv4", 32'(f_rsp_valid), 32'd3);
        chk("bp_res0", f_res0, 32'd30);
        @(negedge clk);
        #1 chk("bp_rdy5", 32'(f_req_ready), 32'd1);
        chk("bp_rv5", 32'(f_rsp_valid), 32'd2);
        @(negedge clk);
        req_valid = 2'b10;
        #1 chk("bp_rdy6", 32'(f_req_ready), 32'd0);
        @(negedge clk);
        rsp_ready = 2'b11;
        #1 chk("bp_rdy7", 32'(f_req_ready), 32'd0);
        @(negedge clk);
        #1 chk("bp_rdy8", 32'(f_req_ready), 32'd2);
        chk("bp_rv8", 32'(f_rsp_valid), 32'd0);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        #1 chk("bp_drain", 32'(f_rsp_valid), 32'd0);

        // reset mid-flight with a pending port-1 response
        rsp_ready = 2'b00;
        @(negedge clk);
        req_valid = 2'b10; req_a1 = 32'd9; req_b1 = 32'd1; req_op1 = 3'b001;
        #1 chk("rm_rdy1", 32'(f_req_ready), 32'd2);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1 chk("rm_pend", 32'(f_rsp_valid), 32'd2);
        req_valid = 2'b01; req_a0 = 32'd5; req_b0 = 32'd3; req_op0 = 3'b000;
        #1 chk("rm_rdy0", 32'(f_req_ready), 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        #1 chk("rm_pre", 32'(f_rsp_valid), 32'd2);
        reset_n = 1'b0;
        #1 chk("rm_async", 32'(f_rsp_valid), 32'd0);
        chk("rm_async_p", 32'(p_rsp_valid), 32'd0);
        chk("rm_res1", f_res1, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("rm_stale", 32'(f_rsp_valid), 32'd0);
        end

        // contention after reset: port 0 wins first, then alternation
        req_valid = 2'b11; rsp_ready = 2'b11;
        req_a0 = 32'd1; req_b0 = 32'd2; req_op0 = 3'b100;
        req_a1 = 32'hFFFF_FFFF; req_b1 = 32'd1; req_op1 = 3'b000;
        for (int k = 0; k < 6; k++) begin
            #1 chk("con_rdy_f", 32'(f_req_ready), 32'(con_rdy[k]));
            chk("con_rdy_p", 32'(p_req_ready), 32'(con_rdy[k]));
            chk("con_rsp", 32'(f_rsp_valid), 32'(con_rsp[k]));
            if (k == 2) begin
                chk("con_res0", f_res0, 32'd1);
                chk("con_z0", 32'(f_z0), 32'd0);
            end
            if (k == 3) begin
                chk("con_res1", f_res1, 32'd0);
                chk("con_z1", 32'(f_z1), 32'd1);
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        repeat (4) @(negedge clk);
        #1 chk("con_drain", 32'(f_rsp_valid), 32'd0);

        // fair vs fixed priority once port 0 has won last
        @(negedge clk);
        req_valid = 2'b01; req_a0 = 32'd1; req_b0 = 32'd1; req_op0 = 3'b000;
        #1 chk("fp_first_f", 32'(f_req_ready), 32'd1);
        chk("fp_first_p", 32'(p_req_ready), 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1 chk("fp_rsp", 32'(f_rsp_valid), 32'd1);
        @(negedge clk);
        req_valid = 2'b11; req_a1 = 32'd4; req_b1 = 32'd4; req_op1 = 3'b001;
        for (int k = 0; k < 5; k++) begin
            #1 chk("fp_rdy_f", 32'(f_req_ready), 32'(fair_f[k]));
            chk("fp_rdy_p", 32'(p_req_ready), 32'(fair_p[k]));
            @(negedge clk);
        end
        req_valid = 2'b00;
        repeat (4) @(negedge clk);
        #1 chk("fp_drain_f", 32'(f_rsp_valid), 32'd0);
        chk("fp_drain_p", 32'(p_rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
